// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Owner FSM with optional lock, bounded lock length and registered read return.
module dm_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wd,
   input  logic              p0_lock,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rd,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wd,
   input  logic              p1_lock,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rd,
   output logic [ADDR_W-1:0] dm_address,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_wd,
   input  logic [DATA_W-1:0] dm_rd
);

   localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   state_t           oth_state;
   logic             last;
   logic             last_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             own_req;
   logic             own_lock;
   logic             oth_req;
   logic             rd0_take;
   logic             rd1_take;

   // grants only exist for the current owner and never in a reset cycle
   assign p0_gnt = (state == OWN0) & p0_req & rst;
   assign p1_gnt = (state == OWN1) & p1_req & rst;

   assign rd0_take = p0_gnt & ~p0_we;
   assign rd1_take = p1_gnt & ~p1_we;

   // drive the memory port from whichever port holds a grant, else park at zero
   always_comb begin
      dm_address = '0;
      dm_we      = 1'b0;
      dm_wd      = '0;
      if (p0_gnt) begin
         dm_address = p0_addr;
         dm_we      = p0_we;
         dm_wd      = p0_wd;
      end else if (p1_gnt) begin
         dm_address = p1_addr;
         dm_we      = p1_we;
         dm_wd      = p1_wd;
      end
   end

   // view the two ports as owner/other so both OWN states share one rule set
   always_comb begin
      own_req   = p0_req;
      own_lock  = p0_lock;
      oth_req   = p1_req;
      oth_state = OWN1;
      if (state == OWN1) begin
         own_req   = p1_req;
         own_lock  = p1_lock;
         oth_req   = p0_req;
         oth_state = OWN0;
      end
   end

   // ownership hand-over, tie-break memory and lock run length
   always_comb begin
      state_nx = state;
      last_nx  = last;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (p0_req & p1_req) begin
               state_nx = last ? OWN0 : OWN1;
            end else if (p0_req) begin
               state_nx = OWN0;
            end else if (p1_req) begin
               state_nx = OWN1;
            end
         end
         default: begin
            if (own_req) begin
               last_nx = (state == OWN1);
               if (oth_req & (~own_lock | (cnt == CNT_MAX))) begin
                  state_nx = oth_state;
                  cnt_nx   = '0;
               end else begin
                  state_nx = state;
                  if (cnt != CNT_MAX) begin
                     cnt_nx = cnt + 1'b1;
                  end
               end
            end else begin
               cnt_nx   = '0;
               state_nx = oth_req ? oth_state : IDLE;
            end
         end
      endcase
   end

   // owner state register; reset favours port 0 on the first tie
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
      end
   end

   // port 0 read return: capture memory data one cycle after the read grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         p0_rvalid <= 1'b0;
         p0_rd     <= '0;
      end else begin
         p0_rvalid <= rd0_take;
         if (rd0_take) begin
            p0_rd <= dm_rd;
         end
      end
   end

   // port 1 read return: capture memory data one cycle after the read grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         p1_rvalid <= 1'b0;
         p1_rd     <= '0;
      end else begin
         p1_rvalid <= rd1_take;
         if (rd1_take) begin
            p1_rd <= dm_rd;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic, with a
// rule-level arbitration model, shadow memory and read-return scoreboard.
module tb_dm_arbiter;

   localparam int MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_v  [2];
   logic        we_v   [2];
   logic        lock_v [2];
   logic [4:0]  addr_v [2];
   logic [31:0] wd_v   [2];

   logic        p0_gnt, p1_gnt;
   logic        p0_rvalid, p1_rvalid;
   logic [31:0] p0_rd, p1_rd;
   logic [4:0]  dm_address;
   logic        dm_we;
   logic [31:0] dm_wd;
   logic [31:0] dm_rd;

   logic [31:0] mem    [32];
   logic [31:0] shadow [32];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   int n_chk  = 0;
   int n_fail = 0;

   int m_owner = -1;
   int m_last  = 1;
   int m_run   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dm_we) mem[dm_address] <= dm_wd;
   end
   assign dm_rd = mem[dm_address];

   dm_arbiter #(
      .ADDR_W   (5),
      .DATA_W   (32),
      .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p0_req     (req_v[0]),
      .p0_we      (we_v[0]),
      .p0_addr    (addr_v[0]),
      .p0_wd      (wd_v[0]),
      .p0_lock    (lock_v[0]),
      .p0_gnt     (p0_gnt),
      .p0_rvalid  (p0_rvalid),
      .p0_rd      (p0_rd),
      .p1_req     (req_v[1]),
      .p1_we      (we_v[1]),
      .p1_addr    (addr_v[1]),
      .p1_wd      (wd_v[1]),
      .p1_lock    (lock_v[1]),
      .p1_gnt     (p1_gnt),
      .p1_rvalid  (p1_rvalid),
      .p1_rd      (p1_rd),
      .dm_address (dm_address),
      .dm_we      (dm_we),
      .dm_wd      (dm_wd),
      .dm_rd      (dm_rd)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic clear_in();
      for (int p = 0; p < 2; p++) begin
         req_v[p]  = 1'b0;
         we_v[p]   = 1'b0;
         lock_v[p] = 1'b0;
         addr_v[p] = '0;
         wd_v[p]   = '0;
      end
   endtask

   // one cycle: check grants and memory port against the rule model,
   // book-keep shadow memory / expected reads, advance model, wait a cycle
   task automatic step(output logic g0, output logic g1);
      logic        eg [2];
      logic [4:0]  ea;
      logic        ew;
      logic [31:0] ed;
      int          o;
      #1;
      for (int p = 0; p < 2; p++)
         eg[p] = rst && (m_owner == p) && req_v[p];
      chk("gnt0", p0_gnt, eg[0]);
      chk("gnt1", p1_gnt, eg[1]);
      chk("gnt_both", p0_gnt & p1_gnt, 0);
      ea = '0; ew = 1'b0; ed = '0;
      for (int p = 0; p < 2; p++) begin
         if (eg[p]) begin
            ea = addr_v[p]; ew = we_v[p]; ed = wd_v[p];
         end
      end
      chk("dm_address", dm_address, ea);
      chk("dm_we", dm_we, ew);
      chk("dm_wd", dm_wd, ed);
      for (int p = 0; p < 2; p++) begin
         if (eg[p]) begin
            if (we_v[p]) shadow[addr_v[p]] = wd_v[p];
            else if (p == 0) q0.push_back(shadow[addr_v[p]]);
            else q1.push_back(shadow[addr_v[p]]);
         end
      end
      if (!rst) begin
         m_owner = -1; m_last = 1; m_run = 0;
      end else if (m_owner < 0) begin
         if (req_v[0] && req_v[1]) m_owner = 1 - m_last;
         else if (req_v[0]) m_owner = 0;
         else if (req_v[1]) m_owner = 1;
      end else begin
         o = 1 - m_owner;
         if (req_v[m_owner]) begin
            m_last = m_owner;
            if (req_v[o] && (!lock_v[m_owner] || m_run == MAX_LOCK - 1)) begin
               m_owner = o; m_run = 0;
            end else if (m_run < MAX_LOCK - 1) begin
               m_run++;
            end
         end else begin
            m_owner = req_v[o] ? o : -1;
            m_run = 0;
         end
      end
      g0 = eg[0];
      g1 = eg[1];
      @(negedge clk);
   endtask

   task automatic do_reset();
      logic a, b;
      rst = 1'b0;
      clear_in();
      step(a, b);
      rst = 1'b1;
   endtask

   // read-return monitor, decoupled from stimulus
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (p0_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rvalid0_unexpected: got rd %h want none at %0t",
                        p0_rd, $time);
            end else chk("rd0", p0_rd, q0.pop_front());
         end
         if (p1_rvalid === 1'b1) begin
            if (q1.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rvalid1_unexpected: got rd %h want none at %0t",
                        p1_rd, $time);
            end else chk("rd1", p1_rd, q1.pop_front());
         end
      end
   end

   initial begin
      logic        g0, g1;
      logic        gl [2];
      logic [31:0] v;
      logic [31:0] init7;
      int          seq [$];
      int          n1;

      for (int i = 0; i < 32; i++) begin
         v = $urandom;
         mem[i] <= v;
         shadow[i] = v;
      end
      init7 = shadow[7];
      rst = 1'b0;
      clear_in();
      @(negedge clk);

      // reset with a pending write
      req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'd7;
      wd_v[0] = 32'hA5A5_0001;
      step(g0, g1);
      step(g0, g1);
      chk("t1_rvalid0", p0_rvalid, 0);
      chk("t1_rvalid1", p1_rvalid, 0);
      chk("t1_rd0", p0_rd, 0);
      chk("t1_rd1", p1_rd, 0);
      chk("t1_mem7", mem[7], init7);

      // single write then read
      rst = 1'b1;
      addr_v[0] = 5'd5; wd_v[0] = 32'hDEAD_BEEF;
      step(g0, g1);
      chk("t2_wr_wait", g0, 0);
      step(g0, g1);
      chk("t2_wr_gnt", g0, 1);
      chk("t2_mem5", mem[5], 32'hDEAD_BEEF);
      we_v[0] = 1'b0;
      step(g0, g1);
      chk("t2_rd_gnt", g0, 1);
      chk("t2_rvalid", p0_rvalid, 1);
      chk("t2_rd", p0_rd, 32'hDEAD_BEEF);
      req_v[0] = 1'b0;
      step(g0, g1);
      chk("t2_pulse", p0_rvalid, 0);
      step(g0, g1);

      // round robin, both ports always requesting
      do_reset();
      for (int p = 0; p < 2; p++) begin
         req_v[p] = 1'b1; addr_v[p] = 5'($urandom_range(0, 31));
      end
      for (int k = 0; k < 7; k++) begin
         step(g0, g1);
         chk("t3_rr0", g0, (k > 0) && (k % 2 == 1));
         chk("t3_rr1", g1, (k > 0) && (k % 2 == 0));
      end
      clear_in();
      step(g0, g1);
      step(g0, g1);

      // locked burst on port 1 against a waiting port 0
      do_reset();
      req_v[1] = 1'b1; lock_v[1] = 1'b1; addr_v[1] = 5'd9;
      step(g0, g1);
      req_v[0] = 1'b1; addr_v[0] = 5'd2;
      seq.delete();
      n1 = 0;
      for (int k = 0; k < 60 && n1 < 20; k++) begin
         step(g0, g1);
         if (g0) seq.push_back(0);
         if (g1) begin
            seq.push_back(1);
            n1++;
            addr_v[1] = 5'($urandom_range(0, 31));
            if (n1 == 20) begin
               req_v[1] = 1'b0; lock_v[1] = 1'b0;
            end
         end
      end
      chk("t4_burst_done", n1, 20);
      if (seq.size() < 10) chk("t4_seq_len", seq.size(), 10);
      else begin
         for (int i = 0; i < 8; i++) chk("t4_p1_run", seq[i], 1);
         chk("t4_p0_turn", seq[8], 0);
         chk("t4_p1_resume", seq[9], 1);
      end
      clear_in();
      step(g0, g1);
      step(g0, g1);

      // write collision to the same word from IDLE
      do_reset();
      for (int p = 0; p < 2; p++) begin
         req_v[p] = 1'b1; we_v[p] = 1'b1; addr_v[p] = 5'd3;
      end
      wd_v[0] = 32'h1; wd_v[1] = 32'h2;
      seq.delete();
      for (int k = 0; k < 6; k++) begin
         step(g0, g1);
         if (g0) begin seq.push_back(0); req_v[0] = 1'b0; end
         if (g1) begin seq.push_back(1); req_v[1] = 1'b0; end
      end
      if (seq.size() != 2) chk("t5_seq_len", seq.size(), 2);
      else begin
         chk("t5_first", seq[0], 0);
         chk("t5_second", seq[1], 1);
      end
      chk("t5_mem3", mem[3], 32'h2);
      clear_in();

      // reset in the middle of a locked read burst
      do_reset();
      req_v[1] = 1'b1; lock_v[1] = 1'b1; addr_v[1] = 5'd5;
      for (int k = 0; k < 4; k++) step(g0, g1);
      rst = 1'b0;
      step(g0, g1);
      chk("t6_rst_gnt", g1, 0);
      chk("t6_rvalid", p1_rvalid, 0);
      rst = 1'b1;
      req_v[0] = 1'b1; addr_v[0] = 5'd5;
      step(g0, g1);
      chk("t6_idle0", g0, 0);
      chk("t6_idle1", g1, 0);
      step(g0, g1);
      chk("t6_first_p0", g0, 1);
      clear_in();
      step(g0, g1);
      step(g0, g1);

      // random traffic
      gl[0] = 1'b0; gl[1] = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 199) != 0);
         for (int p = 0; p < 2; p++) begin
            if (!req_v[p] || gl[p]) begin
               req_v[p]  = ($urandom_range(0, 99) < 65);
               we_v[p]   = 1'($urandom_range(0, 1));
               addr_v[p] = 5'($urandom_range(0, 31));
               wd_v[p]   = $urandom;
               lock_v[p] = ($urandom_range(0, 2) == 0);
            end
         end
         step(gl[0], gl[1]);
      end

      rst = 1'b1;
      clear_in();
      for (int k = 0; k < 4; k++) step(g0, g1);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      for (int i = 0; i < 32; i++) chk("mem_final", mem[i], shadow[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
